// File: rtl/lcd_write_engine_pkg.sv
// Shared state encoding, HD44780 command constants and small helpers for the LCD write engine.
// Pure declarations: no timing, no flow control.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP,
        S_WAIT
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [3:0] LCD_WAKE_NIB  = 4'h3;
    localparam logic [3:0] LCD_4BIT_NIB  = 4'h2;
    localparam logic [7:0] LCD_WAKE_BYTE = 8'h30;

    // The last 4-bit wake-up strobe switches the controller into nibble mode.
    function automatic logic [7:0] wake_value(input logic bus8, input logic [1:0] idx);
        if (bus8) return LCD_WAKE_BYTE;
        return {4'h0, (idx == 2'd3) ? LCD_4BIT_NIB : LCD_WAKE_NIB};
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long settle time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == LCD_CMD_CLEAR) || ({b[7:1], 1'b0} == LCD_CMD_HOME));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// Byte request handshake between the control core and the LCD write engine.
// One byte transfers on any edge where iValid and oReady are both high.
interface lcd_write_engine_if;
    logic       iValid;
    logic [7:0] iData;
    logic       iRS;
    logic       oReady;

    modport master (output iValid, output iData, output iRS, input oReady);
    modport slave  (input iValid, input iData, input iRS, output oReady);
endinterface

// File: rtl/lcd_write_engine_delay_counter.sv
// Reloadable down-counter timing every engine phase; done marks the last cycle of a phase.
// A load of N (0 treated as 1) gives exactly N cycles until the next load.
module lcd_delay_counter #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset)
            cnt <= RST_VAL;
        else if (load)
            cnt <= (load_val == '0) ? W'(1) : load_val;
        else if (en && !done)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt <= W'(1));
endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 write engine: runs the wake-up sequence, then serialises accepted bytes as 1 or 2 E strobes.
// oReady is high only in idle; iValid while busy is ignored, so the host simply holds its byte.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int BUS_8BIT      = 0,
    parameter int LCD_W         = BUS_8BIT ? 8 : 4,
    parameter int POWERUP_CYC   = 750000,
    parameter int INIT_WAIT_CYC = 205000,
    parameter int SETUP_CYC     = 2,
    parameter int ENABLE_CYC    = 12,
    parameter int HOLD_CYC      = 1,
    parameter int GAP_CYC       = 50,
    parameter int CMD_CYC       = 2000,
    parameter int CLEAR_CYC     = 82000
) (
    input  logic              Clock,
    input  logic              Reset,
    lcd_write_engine_if.slave host,
    output logic [LCD_W-1:0]  oLCD,
    output logic              oInitDone,
    output logic              oReadWrite,
    output logic              oRegisterSelect,
    output logic              oEnable
);
    localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, INIT_WAIT_CYC), max_int(SETUP_CYC, ENABLE_CYC)),
                                     max_int(max_int(HOLD_CYC, GAP_CYC), max_int(CMD_CYC, CLEAR_CYC)));
    localparam int         CW        = $clog2(MAX_CYC) + 1;
    localparam logic       IS8       = (BUS_8BIT != 0);
    localparam logic [1:0] WAKE_LAST = IS8 ? 2'd2 : 2'd3;

    lcd_state_t       state, state_nxt;
    logic             cnt_done;
    logic [CW-1:0]    cnt_val;
    logic [7:0]       byte_q;
    logic             rs_q, low_nib, init_active, init_done_q, rs_pin;
    logic [1:0]       wake_idx;
    logic [LCD_W-1:0] lcd_q, setup_dat;
    logic             accept, setup_go, setup_rs, wake_adv, init_finish, go_low;

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_POWERUP;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        setup_go    = 1'b0;
        setup_rs    = 1'b0;
        setup_dat   = '0;
        wake_adv    = 1'b0;
        init_finish = 1'b0;
        go_low      = 1'b0;
        case (state)
            S_POWERUP: if (cnt_done) begin
                state_nxt = S_SETUP;
                setup_go  = 1'b1;
                setup_dat = LCD_W'(wake_value(IS8, 2'd0));
            end
            S_INIT: if (cnt_done) begin
                if (wake_idx == WAKE_LAST) begin
                    state_nxt   = S_IDLE;
                    init_finish = 1'b1;
                end else begin
                    state_nxt = S_SETUP;
                    setup_go  = 1'b1;
                    wake_adv  = 1'b1;
                    setup_dat = LCD_W'(wake_value(IS8, wake_idx + 2'd1));
                end
            end
            S_IDLE: if (host.iValid) begin
                accept    = 1'b1;
                state_nxt = S_SETUP;
                setup_go  = 1'b1;
                setup_rs  = host.iRS;
                // Truncation to a 4-bit bus keeps just the high nibble.
                setup_dat = LCD_W'(IS8 ? host.iData : {4'h0, host.iData[7:4]});
            end
            S_SETUP: if (cnt_done) state_nxt = S_PULSE;
            S_PULSE: if (cnt_done) state_nxt = S_HOLD;
            S_HOLD: if (cnt_done) begin
                if (init_active)          state_nxt = S_INIT;
                else if (!IS8 && !low_nib) state_nxt = S_GAP;
                else                      state_nxt = S_WAIT;
            end
            S_GAP: if (cnt_done) begin
                state_nxt = S_SETUP;
                setup_go  = 1'b1;
                go_low    = 1'b1;
                setup_rs  = rs_q;
                setup_dat = LCD_W'({4'h0, byte_q[3:0]});
            end
            S_WAIT: if (cnt_done) state_nxt = S_IDLE;
            default: state_nxt = S_POWERUP;
        endcase
    end

    always_comb begin
        cnt_val = CW'(POWERUP_CYC);
        case (state_nxt)
            S_INIT:  cnt_val = CW'(INIT_WAIT_CYC);
            S_SETUP: cnt_val = CW'(SETUP_CYC);
            S_PULSE: cnt_val = CW'(ENABLE_CYC);
            S_HOLD:  cnt_val = CW'(HOLD_CYC);
            S_GAP:   cnt_val = CW'(GAP_CYC);
            S_WAIT:  cnt_val = is_long_cmd(rs_q, byte_q) ? CW'(CLEAR_CYC) : CW'(CMD_CYC);
            default: cnt_val = CW'(POWERUP_CYC);
        endcase
    end

    lcd_delay_counter #(.W(CW), .RST_VAL(CW'(POWERUP_CYC))) u_delay (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (state_nxt != state),
        .load_val (cnt_val),
        .en       (state != S_IDLE),
        .done     (cnt_done)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            byte_q      <= '0;
            rs_q        <= 1'b0;
            low_nib     <= 1'b0;
            init_active <= 1'b1;
            init_done_q <= 1'b0;
            wake_idx    <= '0;
            lcd_q       <= '0;
            rs_pin      <= 1'b0;
        end else begin
            if (accept) begin
                byte_q  <= host.iData;
                rs_q    <= host.iRS;
                low_nib <= 1'b0;
            end
            if (go_low)   low_nib  <= 1'b1;
            if (wake_adv) wake_idx <= wake_idx + 2'd1;
            // Bus and RS move only on SETUP entry, so they are stable around every E pulse.
            if (setup_go) begin
                lcd_q  <= setup_dat;
                rs_pin <= setup_rs;
            end
            if (init_finish) begin
                init_active <= 1'b0;
                init_done_q <= 1'b1;
            end
        end
    end

    assign host.oReady     = (state == S_IDLE);
    assign oEnable         = (state == S_PULSE);
    assign oLCD            = lcd_q;
    assign oRegisterSelect = rs_pin;
    assign oReadWrite      = 1'b0;
    assign oInitDone       = init_done_q;
endmodule

// File: tb/tb_lcd_write_engine.sv
// Scoreboard bench for lcd_write_engine: 4-bit and 8-bit instances share clock and reset.
module tb_lcd_write_engine;
    localparam int P_POWERUP = 10, P_INIT = 4, P_SETUP = 1, P_ENABLE = 2;
    localparam int P_HOLD = 1, P_GAP = 3, P_CMD = 5, P_CLEAR = 20;

    typedef struct packed {
        logic [7:0] dat;
        logic       rs;
    } strobe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_write_engine_if bus4 ();
    lcd_write_engine_if bus8 ();
    logic [3:0] lcd4;
    logic [7:0] lcd8;
    logic done4, rw4, rs4, e4, done8, rw8, rs8, e8;

    lcd_write_engine #(.BUS_8BIT(0), .POWERUP_CYC(P_POWERUP), .INIT_WAIT_CYC(P_INIT), .SETUP_CYC(P_SETUP),
        .ENABLE_CYC(P_ENABLE), .HOLD_CYC(P_HOLD), .GAP_CYC(P_GAP), .CMD_CYC(P_CMD), .CLEAR_CYC(P_CLEAR)) dut4 (
        .Clock(clk), .Reset(rst), .host(bus4), .oLCD(lcd4), .oInitDone(done4),
        .oReadWrite(rw4), .oRegisterSelect(rs4), .oEnable(e4));

    lcd_write_engine #(.BUS_8BIT(1), .POWERUP_CYC(P_POWERUP), .INIT_WAIT_CYC(P_INIT), .SETUP_CYC(P_SETUP),
        .ENABLE_CYC(P_ENABLE), .HOLD_CYC(P_HOLD), .GAP_CYC(P_GAP), .CMD_CYC(P_CMD), .CLEAR_CYC(P_CLEAR)) dut8 (
        .Clock(clk), .Reset(rst), .host(bus8), .oLCD(lcd8), .oInitDone(done8),
        .oReadWrite(rw8), .oRegisterSelect(rs8), .oEnable(e8));

    strobe_t q4[$], q8[$];
    strobe_t exp4, exp8;
    int checks = 0, failures = 0;
    int strobes4 = 0, strobes8 = 0, side_bad = 0;
    logic e4_p = 1'b0, e8_p = 1'b0, rs4_p = 1'b0, rs8_p = 1'b0;
    logic [3:0] lcd4_p = '0;
    logic [7:0] lcd8_p = '0;

    function automatic strobe_t mk(input logic [7:0] d, input logic r);
        strobe_t s;
        s.dat = d;
        s.rs  = r;
        return s;
    endfunction

    // Every rising E is matched against the next expected strobe.
    always @(negedge clk) begin
        if (e4 && !e4_p) begin
            strobes4++;
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL strobe4_unexpected: got lcd=%h rs=%b, required no strobe", lcd4, rs4);
            end else begin
                exp4 = q4.pop_front();
                if ({4'h0, lcd4} !== exp4.dat || rs4 !== exp4.rs) begin
                    failures++;
                    $display("FAIL strobe4_value: got lcd=%h rs=%b, required lcd=%h rs=%b", lcd4, rs4, exp4.dat[3:0], exp4.rs);
                end
            end
        end
        if (e8 && !e8_p) begin
            strobes8++;
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL strobe8_unexpected: got lcd=%h rs=%b, required no strobe", lcd8, rs8);
            end else begin
                exp8 = q8.pop_front();
                if (lcd8 !== exp8.dat || rs8 !== exp8.rs) begin
                    failures++;
                    $display("FAIL strobe8_value: got lcd=%h rs=%b, required lcd=%h rs=%b", lcd8, rs8, exp8.dat, exp8.rs);
                end
            end
        end
        if (e4 && e4_p && (lcd4 !== lcd4_p || rs4 !== rs4_p)) side_bad++;
        if (e8 && e8_p && (lcd8 !== lcd8_p || rs8 !== rs8_p)) side_bad++;
        if (rw4 !== 1'b0 || rw8 !== 1'b0) side_bad++;
        e4_p = e4; e8_p = e8; lcd4_p = lcd4; lcd8_p = lcd8; rs4_p = rs4; rs8_p = rs8;
    end

    task automatic apply_reset(input string name);
        int n, b4, b8;
        rst = 1'b1;
        bus4.iValid = 1'b0;
        bus8.iValid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({e4, rs4, rw4, bus4.oReady, done4} !== 5'b0 || lcd4 !== 4'h0) begin
            failures++;
            $display("FAIL %s_values4: got e/rs/rw/rdy/done=%b lcd=%h, required all 0", name,
                     {e4, rs4, rw4, bus4.oReady, done4}, lcd4);
        end
        checks++;
        if ({e8, rs8, rw8, bus8.oReady, done8} !== 5'b0 || lcd8 !== 8'h00) begin
            failures++;
            $display("FAIL %s_values8: got e/rs/rw/rdy/done=%b lcd=%h, required all 0", name,
                     {e8, rs8, rw8, bus8.oReady, done8}, lcd8);
        end
        repeat (3) q4.push_back(mk(8'h03, 1'b0));
        q4.push_back(mk(8'h02, 1'b0));
        repeat (3) q8.push_back(mk(8'h30, 1'b0));
        b4 = strobes4;
        b8 = strobes8;
        rst = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!e4 && n < 100);
        checks++;
        if (n != P_POWERUP + P_SETUP || e8 !== 1'b1) begin
            failures++;
            $display("FAIL %s_first_enable: got %0d cycles (e8=%b), required %0d (e8=1)", name, n, e8, P_POWERUP + P_SETUP);
        end
        n = 0;
        while (!(done4 && done8) && n < 500) begin @(posedge clk); #1; n++; end
        checks++;
        if (!(done4 && bus4.oReady && done8 && bus8.oReady)) begin
            failures++;
            $display("FAIL %s_init_done: got done4=%b rdy4=%b done8=%b rdy8=%b, required all 1", name,
                     done4, bus4.oReady, done8, bus8.oReady);
        end
        checks++;
        if (strobes4 - b4 != 4 || strobes8 - b8 != 3 || q4.size() != 0 || q8.size() != 0) begin
            failures++;
            $display("FAIL %s_wake_count: got %0d/%0d strobes, required 4/3", name, strobes4 - b4, strobes8 - b8);
        end
    endtask

    // Sends one byte and checks the whole busy window cycle by cycle.
    task automatic send(input bit which, input logic [7:0] d, input logic r, input bit jam, input string name);
        int n, k, exp_len, wait_c;
        logic [255:0] got_e, exp_e;
        n = 0;
        while (!(which ? bus8.oReady : bus4.oReady) && n < 500) begin @(posedge clk); #1; n++; end
        checks++;
        if (!(which ? bus8.oReady : bus4.oReady)) begin
            failures++;
            $display("FAIL %s_ready_timeout: got oReady=0 after %0d cycles, required 1", name, n);
            return;
        end
        if (which) begin
            bus8.iValid = 1'b1; bus8.iData = d; bus8.iRS = r;
            q8.push_back(mk(d, r));
        end else begin
            bus4.iValid = 1'b1; bus4.iData = d; bus4.iRS = r;
            q4.push_back(mk({4'h0, d[7:4]}, r));
            q4.push_back(mk({4'h0, d[3:0]}, r));
        end
        @(posedge clk); #1;
        if (!jam) begin bus4.iValid = 1'b0; bus8.iValid = 1'b0; end
        wait_c = (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_CLEAR : P_CMD;
        exp_e = '0;
        k = P_SETUP;
        for (int i = 0; i < P_ENABLE; i++) exp_e[k + i] = 1'b1;
        k += P_ENABLE + P_HOLD;
        if (!which) begin
            k += P_GAP + P_SETUP;
            for (int i = 0; i < P_ENABLE; i++) exp_e[k + i] = 1'b1;
            k += P_ENABLE + P_HOLD;
        end
        exp_len = k + wait_c;
        got_e = '0;
        n = 0;
        while (!(which ? bus8.oReady : bus4.oReady) && n < 250) begin
            got_e[n] = which ? e8 : e4;
            if (jam) begin bus4.iData = 8'($urandom); bus4.iRS = 1'($urandom); end
            n++;
            @(posedge clk); #1;
        end
        bus4.iValid = 1'b0;
        bus8.iValid = 1'b0;
        checks++;
        if (n != exp_len) begin
            failures++;
            $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, n, exp_len);
        end
        checks++;
        if (got_e !== exp_e) begin
            failures++;
            $display("FAIL %s_enable_shape: got %h, required %h", name, got_e, exp_e);
        end
        checks++;
        if ((which ? q8.size() : q4.size()) != 0) begin
            failures++;
            $display("FAIL %s_strobes_left: got %0d pending, required 0", name, which ? q8.size() : q4.size());
        end
        checks++;
        if (side_bad != 0) begin
            failures++;
            $display("FAIL %s_bus_stability: got %0d violations, required 0", name, side_bad);
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_data();
        send(1'b0, 8'h48, 1'b1, 1'b0, "data48");
    endtask

    task automatic test_cmd_wait();
        send(1'b0, 8'h01, 1'b0, 1'b0, "clear01");
        send(1'b0, 8'h0C, 1'b0, 1'b0, "cmd0C");
        send(1'b0, 8'h03, 1'b0, 1'b0, "home03");
        send(1'b0, 8'h01, 1'b1, 1'b0, "char01");
    endtask

    task automatic test_back_to_back();
        send(1'b0, 8'h5A, 1'b1, 1'b1, "jam5A");
        send(1'b0, 8'hC3, 1'b0, 1'b0, "after_jam");
    endtask

    task automatic test_reset_mid();
        int n, b;
        n = 0;
        while (!bus4.oReady && n < 500) begin @(posedge clk); #1; n++; end
        b = strobes4;
        bus4.iValid = 1'b1; bus4.iData = 8'h48; bus4.iRS = 1'b1;
        q4.push_back(mk(8'h04, 1'b1));
        q4.push_back(mk(8'h08, 1'b1));
        @(posedge clk); #1;
        bus4.iValid = 1'b0;
        n = 0;
        while (!(strobes4 == b + 2 && e4) && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (!(strobes4 == b + 2 && e4)) begin
            failures++;
            $display("FAIL rst_mid_reach: got strobes=%0d e=%b, required %0d and 1", strobes4 - b, e4, 2);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (e4 !== 1'b0 || done4 !== 1'b0 || bus4.oReady !== 1'b0 || lcd4 !== 4'h0 || rs4 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got e=%b done=%b rdy=%b lcd=%h rs=%b, required all 0",
                     e4, done4, bus4.oReady, lcd4, rs4);
        end
        apply_reset("rst_mid");
    endtask

    task automatic test_8bit();
        send(1'b1, 8'hA5, 1'b1, 1'b0, "bus8_A5");
        send(1'b1, 8'h01, 1'b0, 1'b0, "bus8_clear");
    endtask

    initial begin
        bus4.iValid = 1'b0; bus4.iData = 8'h00; bus4.iRS = 1'b0;
        bus8.iValid = 1'b0; bus8.iData = 8'h00; bus8.iRS = 1'b0;
        test_reset();
        test_data();
        test_cmd_wait();
        test_back_to_back();
        test_reset_mid();
        test_8bit();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
